ex_mem_reg: RTL and testbench

- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures the execute results each cycle: destination register, GPR write enable/data, and HI/LO write data/enable.
- Presents them to MEM. Feeds the registered HI/LO write back to execute as the mem_hi/mem_lo/mem_whilo forwarding source.
- Converts the execute-stage stop (multi-cycle divide) into a pipeline bubble, holds its contents under a downstream stall, and supports flush.

---
 rtl/ex_mem_reg.sv | 197 +++++++++++++++++++
 tb/tb_ex_mem_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg : EX/MEM pipeline register of the 5-stage MIPS core.
//
// Captures the execute-stage results (destination GPR, GPR write enable and
// data, HI/LO write data and enable) on every rising clock edge and presents
// them to the memory-access stage one cycle later.  The registered HI/LO
// fields double as the execute-stage forwarding source.
//
// Update priority at each edge:
//   flush_i      -> clear everything, EMPTY
//   mem_stall_i  -> hold contents (FULL becomes HOLD)
//   ex_stop_i    -> load a bubble (multi-cycle divide not finished), EMPTY
//   otherwise    -> load the ex_* inputs, FULL
//
// Optional build macro: EX_MEM_PERF_EN
//   defined     : perf_bubble_o / perf_hold_o are free-running 32-bit
//                 counters of bubble loads and held-valid stall cycles,
//                 cleared by rst only.
//   undefined   : no counter logic, both ports tied to zero.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   ex_wd_i/ex_wreg_i/ex_wdata_i      GPR destination, enable, data from EX
//   ex_hi_i/ex_lo_i/ex_whilo_i        HI/LO data and enable from EX
//   ex_stop_i                         EX result not ready (divide running)
//   mem_stall_i                       downstream cannot accept
//   flush_i                           discard register contents
//   mem_wd_o/mem_wreg_o/mem_wdata_o   registered GPR write fields
//   mem_hi_o/mem_lo_o/mem_whilo_o     registered HI/LO fields (also forwarded)
//   valid_o                           register holds a real instruction
//   stall_req_o                       combinational freeze request for IF/ID/EX
//   perf_bubble_o/perf_hold_o         performance counters
// ---------------------------------------------------------------------------
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic [DATA_W-1:0] ex_hi_i,
  input  logic [DATA_W-1:0] ex_lo_i,
  input  logic              ex_whilo_i,
  input  logic              ex_stop_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] mem_wd_o,
  output logic              mem_wreg_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [DATA_W-1:0] mem_hi_o,
  output logic [DATA_W-1:0] mem_lo_o,
  output logic              mem_whilo_o,
  output logic              valid_o,
  output logic              stall_req_o,
  output logic [31:0]       perf_bubble_o,
  output logic [31:0]       perf_hold_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    UPD_FLUSH  = 2'd0,
    UPD_HOLD   = 2'd1,
    UPD_BUBBLE = 2'd2,
    UPD_LOAD   = 2'd3
  } upd_t;

  state_t              state_r;
  upd_t                upd_s;
  logic [ADDR_W-1:0]   wd_r;
  logic                wreg_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic                whilo_r;
  logic                valid_r;

  // Resolve the per-edge update action in priority order.
  always_comb begin
    upd_s = UPD_LOAD;
    if (flush_i) begin
      upd_s = UPD_FLUSH;
    end else if (mem_stall_i) begin
      upd_s = UPD_HOLD;
    end else if (ex_stop_i) begin
      upd_s = UPD_BUBBLE;
    end else begin
      upd_s = UPD_LOAD;
    end
  end

  // Pipeline-register FSM: state plus all registered MEM-side fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      wd_r    <= {ADDR_W{1'b0}};
      wreg_r  <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
      hi_r    <= {DATA_W{1'b0}};
      lo_r    <= {DATA_W{1'b0}};
      whilo_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (upd_s)
        UPD_HOLD: begin
          // Fields are frozen; only the state notes that a valid entry is held.
          case (state_r)
            ST_FULL:  state_r <= ST_HOLD;
            ST_HOLD:  state_r <= ST_HOLD;
            ST_EMPTY: state_r <= ST_EMPTY;
            default:  state_r <= ST_EMPTY;
          endcase
        end
        UPD_LOAD: begin
          // Data fields are captured regardless of their enables.
          state_r <= ST_FULL;
          wd_r    <= ex_wd_i;
          wreg_r  <= ex_wreg_i;
          wdata_r <= ex_wdata_i;
          hi_r    <= ex_hi_i;
          lo_r    <= ex_lo_i;
          whilo_r <= ex_whilo_i;
          valid_r <= 1'b1;
        end
        UPD_FLUSH, UPD_BUBBLE: begin
          // A bubble and a flush look identical downstream: nothing writes.
          state_r <= ST_EMPTY;
          wd_r    <= {ADDR_W{1'b0}};
          wreg_r  <= 1'b0;
          wdata_r <= {DATA_W{1'b0}};
          hi_r    <= {DATA_W{1'b0}};
          lo_r    <= {DATA_W{1'b0}};
          whilo_r <= 1'b0;
          valid_r <= 1'b0;
        end
        default: begin
          state_r <= ST_EMPTY;
          wd_r    <= {ADDR_W{1'b0}};
          wreg_r  <= 1'b0;
          wdata_r <= {DATA_W{1'b0}};
          hi_r    <= {DATA_W{1'b0}};
          lo_r    <= {DATA_W{1'b0}};
          whilo_r <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_wd_o    = wd_r;
  assign mem_wreg_o  = wreg_r;
  assign mem_wdata_o = wdata_r;
  assign mem_hi_o    = hi_r;
  assign mem_lo_o    = lo_r;
  assign mem_whilo_o = whilo_r;
  assign valid_o     = valid_r;

  // The controller must see the freeze in the same cycle, so no register here.
  assign stall_req_o = ex_stop_i | mem_stall_i;

`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_bubble_r;
  logic [31:0] perf_hold_r;

  // Performance counters; they wrap naturally and ignore flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubble_r <= 32'd0;
      perf_hold_r   <= 32'd0;
    end else begin
      if (upd_s == UPD_BUBBLE) begin
        perf_bubble_r <= perf_bubble_r + 32'd1;
      end else begin
        perf_bubble_r <= perf_bubble_r;
      end
      if (mem_stall_i && valid_r) begin
        perf_hold_r <= perf_hold_r + 32'd1;
      end else begin
        perf_hold_r <= perf_hold_r;
      end
    end
  end

  assign perf_bubble_o = perf_bubble_r;
  assign perf_hold_o   = perf_hold_r;
`else
  assign perf_bubble_o = 32'd0;
  assign perf_hold_o   = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ex_wd_i = 5'd0;
  logic        ex_wreg_i = 1'b0;
  logic [31:0] ex_wdata_i = 32'd0;
  logic [31:0] ex_hi_i = 32'd0;
  logic [31:0] ex_lo_i = 32'd0;
  logic        ex_whilo_i = 1'b0;
  logic        ex_stop_i = 1'b0;
  logic        mem_stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_hi_o;
  logic [31:0] mem_lo_o;
  logic        mem_whilo_o;
  logic        valid_o;
  logic        stall_req_o;
  logic [31:0] perf_bubble_o;
  logic [31:0] perf_hold_o;

  int total = 0;
  int bad = 0;

  ex_mem_reg #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .ex_hi_i(ex_hi_i), .ex_lo_i(ex_lo_i), .ex_whilo_i(ex_whilo_i),
    .ex_stop_i(ex_stop_i), .mem_stall_i(mem_stall_i), .flush_i(flush_i),
    .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
    .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o), .mem_whilo_o(mem_whilo_o),
    .valid_o(valid_o), .stall_req_o(stall_req_o),
    .perf_bubble_o(perf_bubble_o), .perf_hold_o(perf_hold_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;    logic wreg;  logic [31:0] wdata;
    logic [31:0] hi;    logic [31:0] lo; logic whilo;
    logic stop; logic stall; logic flush;
    logic [4:0]  e_wd;  logic e_wreg; logic [31:0] e_wdata;
    logic [31:0] e_hi;  logic [31:0] e_lo; logic e_whilo;
    logic e_valid; logic e_sreq;
    int e_pb; int e_ph;   // expected counters when the perf build is enabled
  } vec_t;

  vec_t vecs[$];

  // Reference-model state: the contents a MEM stage should be seeing.
  logic [4:0]  m_wd;   logic m_wreg;  logic [31:0] m_wdata;
  logic [31:0] m_hi;   logic [31:0] m_lo; logic m_whilo; logic m_valid;
  int m_pb; int m_ph;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                       input logic stop, input logic stall, input logic flush);
    ex_wd_i = wd; ex_wreg_i = wreg; ex_wdata_i = wdata;
    ex_hi_i = hi; ex_lo_i = lo; ex_whilo_i = whilo;
    ex_stop_i = stop; mem_stall_i = stall; flush_i = flush;
  endtask

  task automatic add(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                     input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                     input logic stop, input logic stall, input logic flush,
                     input logic [4:0] e_wd, input logic e_wreg, input logic [31:0] e_wdata,
                     input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_whilo,
                     input logic e_valid, input logic e_sreq, input int e_pb, input int e_ph);
    vec_t v;
    v.wd = wd; v.wreg = wreg; v.wdata = wdata; v.hi = hi; v.lo = lo; v.whilo = whilo;
    v.stop = stop; v.stall = stall; v.flush = flush;
    v.e_wd = e_wd; v.e_wreg = e_wreg; v.e_wdata = e_wdata; v.e_hi = e_hi; v.e_lo = e_lo;
    v.e_whilo = e_whilo; v.e_valid = e_valid; v.e_sreq = e_sreq; v.e_pb = e_pb; v.e_ph = e_ph;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] perf_exp(input int n);
`ifdef EX_MEM_PERF_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_outputs(input string tag, input logic [4:0] wd, input logic wreg,
                               input logic [31:0] wdata, input logic [31:0] hi,
                               input logic [31:0] lo, input logic whilo, input logic valid,
                               input int pb, input int ph);
    chk({tag, ".wd"},    {27'd0, mem_wd_o}, {27'd0, wd});
    chk({tag, ".wreg"},  {31'd0, mem_wreg_o}, {31'd0, wreg});
    chk({tag, ".wdata"}, mem_wdata_o, wdata);
    chk({tag, ".hi"},    mem_hi_o, hi);
    chk({tag, ".lo"},    mem_lo_o, lo);
    chk({tag, ".whilo"}, {31'd0, mem_whilo_o}, {31'd0, whilo});
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, valid});
    chk({tag, ".pbub"},  perf_bubble_o, perf_exp(pb));
    chk({tag, ".phold"}, perf_hold_o, perf_exp(ph));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
    m_whilo = 1'b0; m_valid = 1'b0; m_pb = 0; m_ph = 0;
  endtask

  initial begin
    // Directed table: wd wreg wdata hi lo whilo stop stall flush | expected after the edge
    add(5'd5, 1'b1, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0,
        5'd5, 1'b1, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 0, 0);
    add(5'd0, 1'b0, 32'd0, 32'hDEAD0000, 32'h0000BEEF, 1'b1, 1'b0, 1'b0, 1'b0,
        5'd0, 1'b0, 32'd0, 32'hDEAD0000, 32'h0000BEEF, 1'b1, 1'b1, 1'b0, 0, 0);
    add(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0,
        5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 1; i <= 3; i++)
      add(5'd3, 1'b1, 32'h5, 32'h6, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0,
          5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, i, 0);
    add(5'd0, 1'b0, 32'd0, 32'd0, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0,
        5'd0, 1'b0, 32'd0, 32'd0, 32'd7, 1'b1, 1'b1, 1'b0, 3, 0);
    add(5'd2, 1'b1, 32'hAA, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0,
        5'd2, 1'b1, 32'hAA, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 3, 0);
    for (int i = 1; i <= 4; i++)   // last hold cycle also raises stop: still a hold
      add(5'd9, 1'b0, 32'h55 + i, 32'h1, 32'h2, 1'b1, (i == 4), 1'b1, 1'b0,
          5'd2, 1'b1, 32'hAA, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 3, i);
    add(5'd4, 1'b1, 32'h77, 32'h3, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0,
        5'd4, 1'b1, 32'h77, 32'h3, 32'h4, 1'b0, 1'b1, 1'b0, 3, 4);
    add(5'd6, 1'b1, 32'h99, 32'h9, 32'h9, 1'b1, 1'b0, 1'b1, 1'b1,
        5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 3, 5);
    add(5'd6, 1'b1, 32'h99, 32'h9, 32'h9, 1'b1, 1'b0, 1'b1, 1'b0,
        5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 3, 5);
    add(5'd6, 1'b1, 32'h99, 32'h9, 32'h9, 1'b1, 1'b1, 1'b0, 1'b1,
        5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 3, 5);

    // Reset state, sampled while rst is still asserted.
    #2;
    check_outputs("reset", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0);
    do_reset();

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].wd, vecs[i].wreg, vecs[i].wdata, vecs[i].hi, vecs[i].lo, vecs[i].whilo,
            vecs[i].stop, vecs[i].stall, vecs[i].flush);
      #1;
      chk({tag, ".sreq"}, {31'd0, stall_req_o}, {31'd0, vecs[i].e_sreq});
      @(posedge clk); #1;
      check_outputs(tag, vecs[i].e_wd, vecs[i].e_wreg, vecs[i].e_wdata, vecs[i].e_hi,
                    vecs[i].e_lo, vecs[i].e_whilo, vecs[i].e_valid, vecs[i].e_pb, vecs[i].e_ph);
      @(negedge clk);
    end

    // Asynchronous reset between edges while holding a valid entry.
    drive(5'd1, 1'b1, 32'h1111, 32'h2222, 32'h3333, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("arst.pre_wdata", mem_wdata_o, 32'h1111);
    @(negedge clk);
    drive(5'd1, 1'b1, 32'h4444, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("arst.hold_wdata", mem_wdata_o, 32'h1111);
    #2 rst = 1'b1;
    #1;
    check_outputs("arst", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;

    // Randomized phase against the behavioural model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      logic stop, stall, flush;
      stop  = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      drive(5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
            stop, stall, flush);
      #1;
      chk($sformatf("rnd%0d.sreq", c), {31'd0, stall_req_o}, {31'd0, stop | stall});
      if (stall && m_valid) m_ph++;
      if (flush) begin
        m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
        m_whilo = 1'b0; m_valid = 1'b0;
      end else if (stall) begin
        m_valid = m_valid;
      end else if (stop) begin
        m_pb++;
        m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
        m_whilo = 1'b0; m_valid = 1'b0;
      end else begin
        m_wd = ex_wd_i; m_wreg = ex_wreg_i; m_wdata = ex_wdata_i; m_hi = ex_hi_i;
        m_lo = ex_lo_i; m_whilo = ex_whilo_i; m_valid = 1'b1;
      end
      @(posedge clk); #1;
      check_outputs($sformatf("rnd%0d", c), m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo,
                    m_valid, m_pb, m_ph);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
